// File: rtl/vend_session_ctrl.sv
// vend_session_ctrl: coin credit accumulation, dispense handshake, change/refund payout
module vend_session_ctrl #(
  parameter int PRICE   = 4,
  parameter int CW      = 4,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Coin1,
  input  logic          Coin2,
  input  logic          Cancel,
  input  logic          Disp_ack,
  output logic          Disp_req,
  output logic          Change_out,
  output logic          Coin_reject,
  output logic [CW-1:0] Credit,
  output logic          Busy
);
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    COLLECT  = 4'b0010,
    DISPENSE = 4'b0100,
    CHANGE   = 4'b1000
  } state_t;
  localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE);
  localparam logic [CW:0]   CMAX    = {1'b0, {CW{1'b1}}};
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);
  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [CW-1:0] credit_n;
  logic          rej_n, accept, open_st;
  logic [1:0]    v;
  logic [CW:0]   sum;
  assign v          = {Coin2, Coin1};
  assign open_st    = (state == IDLE) || (state == COLLECT);
  assign sum        = (state == IDLE ? '0 : {1'b0, Credit}) + (CW+1)'(v);
  assign accept     = open_st && (v != 2'd0) && !Cancel && (sum <= CMAX);
  assign Disp_req   = (state == DISPENSE);
  assign Change_out = (state == CHANGE);
  assign Busy       = Disp_req || Change_out;
  // state, credit, timeout counter and reject pulse registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      Credit      <= '0;
      cnt         <= '0;
      Coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      Credit      <= credit_n;
      cnt         <= cnt_n;
      Coin_reject <= rej_n;
    end
  end
  // next-state, credit update and timeout counting
  always_comb begin
    state_n  = state;
    credit_n = Credit;
    cnt_n    = '0;
    rej_n    = (v != 2'd0) && !accept;
    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          credit_n = sum[CW-1:0];
          state_n  = (sum >= PRICE_W) ? DISPENSE : COLLECT;
        end else if (state == COLLECT) begin
          if (Cancel || cnt == TLAST) state_n = CHANGE;
          else cnt_n = cnt + TW'(1);
        end
      end
      DISPENSE: begin
        if (Disp_ack) begin
          credit_n = Credit - PRICE_W[CW-1:0];
          state_n  = ({1'b0, Credit} > PRICE_W) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        credit_n = (Credit <= CW'(1)) ? '0 : Credit - CW'(1);
        state_n  = (Credit <= CW'(1)) ? IDLE : CHANGE;
      end
      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase
  end
endmodule

// File: doc/vend_session_ctrl.md
Name: vend_session_ctrl

Overview:
- Session controller for the coin-operated vending datapath.
- Accepts coin pulses from two coin slots (1-unit and 2-unit coins) and accumulates credit against a fixed price.
- Sequences the dispense mechanism through a req/ack handshake, then pays out change one unit per cycle.
- Refunds the credit on Cancel or on a coin-inactivity timeout; rejects coins that arrive when they cannot be accepted.

Parameters:
PRICE, 4, product price in coin units (1..2^CW-1)
CW, 4, credit register width in bits
TIMEOUT, 16, idle cycles in COLLECT before auto-refund (>=2)
TW, 5, timeout counter width (2^TW > TIMEOUT)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high
Coin1  input  1  1-unit coin pulse, sampled each rising edge
Coin2  input  1  2-unit coin pulse; Coin1&Coin2 in the same cycle = 3 units
Cancel  input  1  customer refund request, sampled each edge
Disp_ack  input  1  dispenser done, level-sampled while Disp_req=1
Disp_req  output  1  dispense request (Moore: state==DISPENSE)
Change_out  output  1  one unit of change/refund per high cycle (Moore: state==CHANGE)
Coin_reject  output  1  registered one-cycle pulse, coin presented but not accepted
Credit  output  CW  current credit register
Busy  output  1  state is DISPENSE or CHANGE

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE, Credit=0, timeout counter=0.
  - Disp_req=0, Change_out=0, Coin_reject=0, Busy=0.
  - Any in-flight dispense or refund is abandoned.
- States are one-hot: IDLE, COLLECT, DISPENSE, CHANGE. Illegal encoding -> IDLE on the next edge.
- Coin value v = Coin1 + 2*Coin2, range 0..3.
- Coin acceptance rule, IDLE/COLLECT only:
  - Accept if v>0, Cancel=0 and Credit+v <= 2^CW-1.
  - Otherwise any v>0 sets Coin_reject=1 for the following cycle.
  - In DISPENSE/CHANGE every coin is rejected the same way.
  - The adder is computed at CW+1 bits, so overflow never wraps.
- IDLE:
  - Coin accepted: Credit<=v. If v>=PRICE -> DISPENSE, else -> COLLECT.
  - Cancel is ignored.
- COLLECT:
  - Coin accepted: Credit<=Credit+v, timeout counter<=0. If Credit+v>=PRICE -> DISPENSE, else stay.
  - Cancel=1 -> CHANGE (refund of full credit); a coin in the same cycle is rejected.
  - No accepted coin and no Cancel: counter increments. At the edge where counter==TIMEOUT-1 -> CHANGE.
- DISPENSE:
  - Disp_req=1 until the edge on which Disp_ack=1.
  - At that edge: Credit<=Credit-PRICE, counter<=0. Next state is CHANGE if Credit-PRICE>0, else IDLE.
  - Cancel is ignored; the purchase is committed.
  - Disp_ack while not in DISPENSE is ignored.
- CHANGE:
  - Change_out=1 every cycle; Credit decrements by 1 at each edge.
  - At the edge where Credit==1 -> IDLE with Credit=0.
  - Change_out is therefore high for exactly N consecutive cycles, where N is the credit on entry.
  - CHANGE is never entered with Credit=0.
- Latency:
  - Disp_req rises on the first edge after the coin that reaches PRICE.
  - Change_out rises on the edge of the Disp_ack, Cancel or timeout that triggers it.
- Outputs: Credit and Coin_reject are registers. Disp_req, Change_out and Busy are decoded from the state register only.

Test Plan:
- Reset, then Coin1 for 4 single cycles spaced 2 apart:
  - Credit steps 1,2,3,4.
  - Disp_req rises the edge after the 4th coin.
  - Disp_ack held 1 cycle -> Credit=0, IDLE, Change_out never high.
- Coin2 then Coin1&Coin2 (credit 5): DISPENSE; ack -> Credit=1, Change_out high exactly 1 cycle, then IDLE.
- Coin2 (credit 2), then Cancel together with Coin1:
  - Coin_reject pulses 1 cycle.
  - Change_out high 2 cycles, Credit 2->1->0.
- Coin1 then no activity:
  - Change_out asserts TIMEOUT=16 cycles after the coin edge, for 1 cycle; state IDLE.
- During DISPENSE (Disp_ack held 0 for 5 cycles), pulse Coin2 and Cancel:
  - Coin_reject pulses, Credit unchanged, Disp_req stays 1.
  - After ack, normal completion.
- Assert Reset mid-CHANGE with Credit=2: all outputs 0 immediately (async); after release, Coin1 is accepted normally.
